// File: rtl/wisc_pkg.sv
// Shared types and default widths for the unified-memory front end.
package wisc_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    HALTED  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_lat_timer.sv
// Memory latency timer: load starts a MEM_LAT-cycle countdown and done_o marks the
// cycle in which read data is present on the memory bus.
module mem_lat_timer #(
  parameter int MEM_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(MEM_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded in the strobe cycle, so a count of one lands on strobe + MEM_LAT.
  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data stage; one access
// in flight, data wins unless fetch has been passed over STARVE_LIM times in a row.
module mem_port_arbiter
  import wisc_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              halt,
  output logic              halted,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  arb_state_t        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              grant_if, grant_d;
  logic              lat_done, acc_done;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              acc_we_q, acc_we_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  mem_lat_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (mem_en_q),
    .done_o (lat_done)
  );

  assign acc_done = lat_done && ((state_q == BUSY_IF) || (state_q == BUSY_D));

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALTED;
        end else if (d_req && (!if_req || (starve_q < SW'(STARVE_LIM)))) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
          if (if_req && (starve_q < SW'(STARVE_LIM))) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (if_req) begin
          grant_if = 1'b1;
          state_d  = BUSY_IF;
          starve_d = '0;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (acc_done) begin
          state_d = halt ? HALTED : IDLE;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_en_d    = grant_if | grant_d;
    mem_we_d    = grant_d & d_we;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    acc_we_d    = acc_we_q;
    if (grant_d) begin
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      acc_we_d    = d_we;
    end else if (grant_if) begin
      mem_addr_d  = if_addr;
    end

    if_valid_d = acc_done && (state_q == BUSY_IF);
    d_valid_d  = acc_done && (state_q == BUSY_D);
    if_rdata_d = if_valid_d ? mem_rdata : if_rdata_q;
    d_rdata_d  = d_rdata_q;
    // Writes report completion with a zeroed data word.
    if (d_valid_d) begin
      d_rdata_d = acc_we_q ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      acc_we_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      acc_we_q    <= acc_we_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Combinational outputs are masked while reset is held so every output reads 0.
  assign if_gnt    = rst_n & grant_if;
  assign d_gnt     = rst_n & grant_d;
  assign stall_if  = rst_n & if_req & ~if_valid_q;
  assign stall_mem = rst_n & d_req & ~d_valid_q;

  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign halted    = (state_q == HALTED);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-numbered transaction model.
module tb_mem_port_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 4;
  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, halt = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic          if_gnt, if_valid, d_gnt, d_valid, halted, stall_if, stall_mem;
  logic          mem_en, mem_we;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .MEM_LAT (LAT), .STARVE_LIM (LIM)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .if_req (if_req), .if_addr (if_addr), .if_gnt (if_gnt), .if_valid (if_valid),
    .if_rdata (if_rdata),
    .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
    .d_gnt (d_gnt), .d_valid (d_valid), .d_rdata (d_rdata),
    .halt (halt), .halted (halted), .stall_if (stall_if), .stall_mem (stall_mem),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: each access is a set of absolute cycle numbers derived at grant time.
  int          free_cyc, park_cyc, en_cyc, cap_cyc, vld_cyc, starve, park_streak;
  bit          acc_d, acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata, e_if_rdata, e_d_rdata;
  int          if_st, d_st;  // 0 idle, 1 requesting, 2 granted and waiting

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    free_cyc    = cyc;
    park_cyc    = 1 << 30;
    en_cyc      = -10;
    cap_cyc     = -10;
    vld_cyc     = -10;
    starve      = 0;
    park_streak = 0;
    acc_d       = 1'b0;
    acc_we      = 1'b0;
    acc_addr    = '0;
    acc_wdata   = '0;
    e_if_rdata  = '0;
    e_d_rdata   = '0;
    if (if_st == 2) if_st = 0;
    if (d_st == 2) d_st = 0;
    if_req = (if_st == 1);
    d_req  = (d_st == 1);
  endtask

  task automatic drive();
    if (if_st == 0 && $urandom_range(0, 3) != 0) begin
      if_st   = 1;
      if_addr = AW'($urandom);
    end else if (if_st == 1 && $urandom_range(0, 15) == 0) begin
      if_st = 0;
    end
    if (d_st == 0 && $urandom_range(0, 2) != 0) begin
      d_st    = 1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = AW'($urandom);
      d_wdata = DW'($urandom);
    end else if (d_st == 1 && $urandom_range(0, 15) == 0) begin
      d_st = 0;
    end
    if_req    = (if_st == 1);
    d_req     = (d_st == 1);
    halt      = ($urandom_range(0, 79) == 0);
    mem_rdata = DW'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_if_gnt",    32'(if_gnt),    32'(0));
    check_eq("rst_d_gnt",     32'(d_gnt),     32'(0));
    check_eq("rst_if_valid",  32'(if_valid),  32'(0));
    check_eq("rst_d_valid",   32'(d_valid),   32'(0));
    check_eq("rst_if_rdata",  32'(if_rdata),  32'(0));
    check_eq("rst_d_rdata",   32'(d_rdata),   32'(0));
    check_eq("rst_halted",    32'(halted),    32'(0));
    check_eq("rst_stall_if",  32'(stall_if),  32'(0));
    check_eq("rst_stall_mem", 32'(stall_mem), 32'(0));
    check_eq("rst_mem_en",    32'(mem_en),    32'(0));
    check_eq("rst_mem_we",    32'(mem_we),    32'(0));
    check_eq("rst_mem_addr",  32'(mem_addr),  32'(0));
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Called mid-cycle with inputs settled: compare, then advance the model.
  task automatic step();
    bit idle, gd, gi, e_ifv, e_dv, e_en;
    idle  = (cyc >= free_cyc) && (cyc < park_cyc);
    gd    = idle && !halt && d_req && (!if_req || starve < LIM);
    gi    = idle && !halt && !gd && if_req;
    e_ifv = (cyc == vld_cyc) && !acc_d;
    e_dv  = (cyc == vld_cyc) && acc_d;
    e_en  = (cyc == en_cyc);

    check_eq("if_gnt",    32'(if_gnt),    32'(gi));
    check_eq("d_gnt",     32'(d_gnt),     32'(gd));
    check_eq("if_valid",  32'(if_valid),  32'(e_ifv));
    check_eq("d_valid",   32'(d_valid),   32'(e_dv));
    check_eq("if_rdata",  32'(if_rdata),  32'(e_if_rdata));
    check_eq("d_rdata",   32'(d_rdata),   32'(e_d_rdata));
    check_eq("halted",    32'(halted),    32'(cyc >= park_cyc));
    check_eq("stall_if",  32'(stall_if),  32'(if_req && !e_ifv));
    check_eq("stall_mem", 32'(stall_mem), 32'(d_req && !e_dv));
    check_eq("mem_en",    32'(mem_en),    32'(e_en));
    check_eq("mem_we",    32'(mem_we),    32'(e_en && acc_we));
    check_eq("mem_addr",  32'(mem_addr),  e_en ? 32'(acc_addr) : 32'(0));
    check_eq("mem_wdata", 32'(mem_wdata), e_en ? 32'(acc_wdata) : 32'(0));

    if (cyc == cap_cyc) begin
      if (acc_d) e_d_rdata = acc_we ? '0 : mem_rdata;
      else       e_if_rdata = mem_rdata;
      if (halt) park_cyc = cyc + 1;
    end
    if (idle && halt) park_cyc = cyc + 1;
    if (e_ifv) if_st = 0;
    if (e_dv)  d_st = 0;
    if (gd || gi) begin
      acc_d     = gd;
      acc_we    = gd && d_we;
      acc_addr  = gd ? d_addr : if_addr;
      acc_wdata = gd ? d_wdata : '0;
      en_cyc    = cyc + 1;
      cap_cyc   = cyc + 1 + LAT;
      vld_cyc   = cyc + 2 + LAT;
      free_cyc  = vld_cyc;
    end
    if (gd && if_req && starve < LIM) starve++;
    if (gi) starve = 0;
    if (gi) if_st = 2;
    if (gd) d_st = 2;
    park_streak = (cyc >= park_cyc) ? park_streak + 1 : 0;
  endtask

  initial begin
    if_st = 0;
    d_st  = 0;
    @(posedge clk); cyc++;
    #1;
    drive();
    do_reset();
    @(negedge clk);
    step();
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); cyc++;
      #1;
      drive();
      if (park_streak > 15 || $urandom_range(0, 249) == 0) do_reset();
      @(negedge clk);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
